// File: rtl/breakout_pkg.sv
// Shared definitions for the breakout game controller: state encoding,
// parameter defaults and score width.
package breakout_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_LOST  = 3'd3,
        ST_CLEAR = 3'd4,
        ST_OVER  = 3'd5
    } game_state_t;

    localparam int START_LIVES_DEF  = 3;
    localparam int PAUSE_FRAMES_DEF = 60;
    localparam int SCORE_W          = 16;

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD counter that saturates at 9999, with synchronous clear
// and an increment enable.
import breakout_pkg::*;

module bcd_counter4 (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clr,
    input  logic               i_inc,
    output logic [SCORE_W-1:0] o_count
);

    logic [SCORE_W-1:0] r_count;
    logic [SCORE_W-1:0] w_next;
    logic               w_atMax;

    assign w_atMax = (r_count == 16'h9999);

    // Ripple a carry through the digits; a digit at 9 wraps and passes it on.
    always_comb begin
        logic carry;
        w_next = r_count;
        carry  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r_count[4*i +: 4] == 4'd9) begin
                    w_next[4*i +: 4] = 4'd0;
                end else begin
                    w_next[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                    carry            = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc && !w_atMax) begin
            r_count <= w_next;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/breakout_game_ctrl.sv
// Breakout game flow controller: serve/play/pause sequencing, lives, level,
// BCD score and paddle step pulses. All outputs are registered.
import breakout_pkg::*;

module breakout_game_ctrl #(
    parameter int START_LIVES  = START_LIVES_DEF,
    parameter int PAUSE_FRAMES = PAUSE_FRAMES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_select,
    input  logic               ball_lost,
    input  logic               brick_hit,
    input  logic               bricks_clear,
    output logic [2:0]         game_state,
    output logic               ball_run,
    output logic               ball_serve,
    output logic               bricks_reload,
    output logic               paddle_left,
    output logic               paddle_right,
    output logic [1:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         level
);

    game_state_t r_state, w_stateNext;
    logic        r_selPrev;
    logic [7:0]  r_pauseCnt;
    logic [1:0]  r_lives;
    logic [3:0]  r_level;
    logic        r_ballRun, r_ballServe, r_bricksReload;
    logic        r_paddleLeft, r_paddleRight;

    logic w_selEdge, w_pauseDone, w_inPaddleState;
    logic w_startGame, w_serve, w_reload, w_loseLife, w_levelInc, w_pauseClr;

    assign w_selEdge       = btn_select & ~r_selPrev;
    assign w_pauseDone     = frame_tick && (r_pauseCnt == 8'(PAUSE_FRAMES - 1));
    assign w_inPaddleState = (r_state == ST_SERVE) || (r_state == ST_PLAY);

    always_comb begin
        w_stateNext = r_state;
        w_startGame = 1'b0;
        w_serve     = 1'b0;
        w_reload    = 1'b0;
        w_loseLife  = 1'b0;
        w_levelInc  = 1'b0;
        w_pauseClr  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_selEdge) begin
                    w_stateNext = ST_SERVE;
                    w_startGame = 1'b1;
                    w_serve     = 1'b1;
                    w_reload    = 1'b1;
                end
            end
            ST_SERVE: begin
                if (w_selEdge) w_stateNext = ST_PLAY;
            end
            ST_PLAY: begin
                // A cleared field takes priority over a lost ball.
                if (bricks_clear) begin
                    w_stateNext = ST_CLEAR;
                    w_pauseClr  = 1'b1;
                end else if (ball_lost) begin
                    w_loseLife  = 1'b1;
                    w_pauseClr  = 1'b1;
                    w_stateNext = (r_lives > 2'd1) ? ST_LOST : ST_OVER;
                end
            end
            ST_LOST: begin
                if (w_pauseDone) begin
                    w_stateNext = ST_SERVE;
                    w_serve     = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (w_pauseDone) begin
                    w_stateNext = ST_SERVE;
                    w_serve     = 1'b1;
                    w_reload    = 1'b1;
                    w_levelInc  = 1'b1;
                end
            end
            ST_OVER: begin
                if (w_selEdge) w_stateNext = ST_IDLE;
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_selPrev      <= 1'b1;
            r_pauseCnt     <= '0;
            r_lives        <= '0;
            r_level        <= '0;
            r_ballRun      <= 1'b0;
            r_ballServe    <= 1'b0;
            r_bricksReload <= 1'b0;
            r_paddleLeft   <= 1'b0;
            r_paddleRight  <= 1'b0;
        end else begin
            r_state        <= w_stateNext;
            r_selPrev      <= btn_select;
            r_ballRun      <= (w_stateNext == ST_PLAY);
            r_ballServe    <= w_serve;
            r_bricksReload <= w_reload;
            r_paddleLeft   <= frame_tick && w_inPaddleState && btn_left && !btn_right;
            r_paddleRight  <= frame_tick && w_inPaddleState && btn_right && !btn_left;

            if (w_pauseClr) begin
                r_pauseCnt <= '0;
            end else if (frame_tick && ((r_state == ST_LOST) || (r_state == ST_CLEAR))) begin
                r_pauseCnt <= r_pauseCnt + 8'd1;
            end

            if (w_startGame) begin
                r_lives <= 2'(START_LIVES);
            end else if (w_loseLife) begin
                r_lives <= r_lives - 2'd1;
            end

            if (w_startGame) begin
                r_level <= '0;
            end else if (w_levelInc && (r_level != 4'd15)) begin
                r_level <= r_level + 4'd1;
            end
        end
    end

    bcd_counter4 u_score (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_startGame),
        .i_inc   (brick_hit && (r_state == ST_PLAY)),
        .o_count (score)
    );

    assign game_state    = r_state;
    assign ball_run      = r_ballRun;
    assign ball_serve    = r_ballServe;
    assign bricks_reload = r_bricksReload;
    assign paddle_left   = r_paddleLeft;
    assign paddle_right  = r_paddleRight;
    assign lives         = r_lives;
    assign level         = r_level;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Directed self-checking bench for breakout_game_ctrl.
module tb_breakout_game_ctrl;

    logic        clk = 1'b0;
    logic        rst, frame_tick, btn_left, btn_right, btn_select;
    logic        ball_lost, brick_hit, bricks_clear;
    logic [2:0]  game_state;
    logic        ball_run, ball_serve, bricks_reload, paddle_left, paddle_right;
    logic [1:0]  lives;
    logic [15:0] score;
    logic [3:0]  level;

    int vecCount  = 0;
    int missCount = 0;
    int serveCnt  = 0;
    int reloadCnt = 0;
    int padLCnt   = 0;
    int padRCnt   = 0;

    breakout_game_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .frame_tick    (frame_tick),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .btn_select    (btn_select),
        .ball_lost     (ball_lost),
        .brick_hit     (brick_hit),
        .bricks_clear  (bricks_clear),
        .game_state    (game_state),
        .ball_run      (ball_run),
        .ball_serve    (ball_serve),
        .bricks_reload (bricks_reload),
        .paddle_left   (paddle_left),
        .paddle_right  (paddle_right),
        .lives         (lives),
        .score         (score),
        .level         (level)
    );

    always #5 clk = ~clk;

    // Pulse outputs are tallied mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (ball_serve)    serveCnt++;
        if (bricks_reload) reloadCnt++;
        if (paddle_left)   padLCnt++;
        if (paddle_right)  padRCnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clearCounts();
        serveCnt  = 0;
        reloadCnt = 0;
        padLCnt   = 0;
        padRCnt   = 0;
    endtask

    task automatic selectEdge();
        btn_select = 1'b1;
        applyStimulus(1);
        btn_select = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            applyStimulus(1);
            frame_tick = 1'b0;
            applyStimulus(1);
        end
    endtask

    task automatic hits(input int n);
        brick_hit = 1'b1;
        applyStimulus(n);
        brick_hit = 1'b0;
    endtask

    initial begin
        rst = 1'b1; frame_tick = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        btn_select = 1'b1; ball_lost = 1'b0; brick_hit = 1'b0; bricks_clear = 1'b0;
        applyStimulus(2);
        checkOutput("rst_state", 32'(game_state), 32'd0);
        checkOutput("rst_lives", 32'(lives), 32'd0);
        checkOutput("rst_score", 32'(score), 32'h0);
        checkOutput("rst_level", 32'(level), 32'd0);
        checkOutput("rst_run", 32'(ball_run), 32'd0);
        clearCounts();

        // Select held through reset must not start a game.
        rst = 1'b0;
        applyStimulus(5);
        checkOutput("held_sel_state", 32'(game_state), 32'd0);
        checkOutput("held_sel_serve", 32'(serveCnt), 32'd0);

        btn_select = 1'b0;
        applyStimulus(1);
        selectEdge();
        checkOutput("start_state", 32'(game_state), 32'd1);
        checkOutput("start_lives", 32'(lives), 32'd3);
        checkOutput("start_score", 32'(score), 32'h0);
        checkOutput("start_serve_now", 32'(ball_serve), 32'd1);
        applyStimulus(3);
        checkOutput("start_serve_cnt", 32'(serveCnt), 32'd1);
        checkOutput("start_reload_cnt", 32'(reloadCnt), 32'd1);
        checkOutput("serve_run", 32'(ball_run), 32'd0);

        // Paddle steps in SERVE.
        clearCounts();
        btn_left = 1'b1;
        frames(3);
        checkOutput("pad_left_cnt", 32'(padLCnt), 32'd3);
        checkOutput("pad_right_cnt", 32'(padRCnt), 32'd0);
        clearCounts();
        btn_right = 1'b1;
        frames(3);
        checkOutput("pad_both_l", 32'(padLCnt), 32'd0);
        checkOutput("pad_both_r", 32'(padRCnt), 32'd0);
        btn_left = 1'b0;
        clearCounts();
        frames(2);
        checkOutput("pad_right_only", 32'(padRCnt), 32'd2);
        btn_right = 1'b0;

        // Hits outside PLAY are ignored.
        hits(3);
        checkOutput("serve_hit_ignored", 32'(score), 32'h0);

        selectEdge();
        checkOutput("play_state", 32'(game_state), 32'd2);
        checkOutput("play_run", 32'(ball_run), 32'd1);

        hits(9);
        checkOutput("score_9", 32'(score), 32'h0009);
        hits(1);
        checkOutput("score_10", 32'(score), 32'h0010);
        hits(85);
        checkOutput("score_95", 32'(score), 32'h0095);
        hits(10);
        checkOutput("score_105", 32'(score), 32'h0105);
        hits(9894);
        checkOutput("score_9999", 32'(score), 32'h9999);
        hits(1);
        checkOutput("score_sat", 32'(score), 32'h9999);

        // Lose a life, sit out the pause, re-serve.
        clearCounts();
        ball_lost = 1'b1;
        applyStimulus(1);
        ball_lost = 1'b0;
        checkOutput("lost_state", 32'(game_state), 32'd3);
        checkOutput("lost_lives", 32'(lives), 32'd2);
        checkOutput("lost_run", 32'(ball_run), 32'd0);
        frames(59);
        checkOutput("lost_59", 32'(game_state), 32'd3);
        frame_tick = 1'b1;
        applyStimulus(1);
        frame_tick = 1'b0;
        checkOutput("lost_exit_state", 32'(game_state), 32'd1);
        checkOutput("lost_exit_serve", 32'(ball_serve), 32'd1);
        checkOutput("lost_exit_reload", 32'(bricks_reload), 32'd0);
        applyStimulus(1);

        // Clear and lost together: clear wins, no life lost.
        selectEdge();
        checkOutput("play2_state", 32'(game_state), 32'd2);
        ball_lost = 1'b1; bricks_clear = 1'b1;
        applyStimulus(1);
        ball_lost = 1'b0; bricks_clear = 1'b0;
        checkOutput("clear_state", 32'(game_state), 32'd4);
        checkOutput("clear_lives", 32'(lives), 32'd2);
        frames(59);
        checkOutput("clear_59", 32'(game_state), 32'd4);
        checkOutput("clear_level_hold", 32'(level), 32'd0);
        frame_tick = 1'b1;
        applyStimulus(1);
        frame_tick = 1'b0;
        checkOutput("clear_exit_state", 32'(game_state), 32'd1);
        checkOutput("clear_level", 32'(level), 32'd1);
        checkOutput("clear_reload", 32'(bricks_reload), 32'd1);
        checkOutput("clear_serve", 32'(ball_serve), 32'd1);
        applyStimulus(1);

        // Burn down to the last life, then game over.
        selectEdge();
        ball_lost = 1'b1;
        applyStimulus(1);
        ball_lost = 1'b0;
        checkOutput("lost2_lives", 32'(lives), 32'd1);
        frames(60);
        checkOutput("lost2_back", 32'(game_state), 32'd1);
        selectEdge();
        ball_lost = 1'b1;
        applyStimulus(1);
        ball_lost = 1'b0;
        checkOutput("over_state", 32'(game_state), 32'd5);
        checkOutput("over_lives", 32'(lives), 32'd0);
        checkOutput("over_run", 32'(ball_run), 32'd0);
        checkOutput("over_score", 32'(score), 32'h9999);
        checkOutput("over_level", 32'(level), 32'd1);
        applyStimulus(1);
        selectEdge();
        checkOutput("idle_state", 32'(game_state), 32'd0);
        hits(2);
        checkOutput("idle_score_held", 32'(score), 32'h9999);

        // New game resets score and level.
        applyStimulus(1);
        selectEdge();
        checkOutput("restart_score", 32'(score), 32'h0);
        checkOutput("restart_level", 32'(level), 32'd0);
        checkOutput("restart_lives", 32'(lives), 32'd3);

        // Mid-game reset with pending paddle step.
        applyStimulus(1);
        rst = 1'b1; frame_tick = 1'b1; btn_left = 1'b1;
        applyStimulus(1);
        rst = 1'b0; frame_tick = 1'b0; btn_left = 1'b0;
        checkOutput("midrst_state", 32'(game_state), 32'd0);
        checkOutput("midrst_pad", 32'(paddle_left), 32'd0);
        checkOutput("midrst_lives", 32'(lives), 32'd0);
        checkOutput("midrst_score", 32'(score), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
